// File: rtl/rom_line_buf.sv
// Direct-mapped 32-bit line buffer in front of the SDRAM port for 16-bit ROM fetches.
// Hits answer one ce period after the start strobe; misses issue one word fill.
module rom_line_buf #(
  parameter int unsigned LINES = 16,
  parameter int unsigned AW    = 20
) (
  input  logic          clk_cpu,
  input  logic          reset,
  input  logic          ce,
  input  logic [AW-1:0] cpu_a,
  input  logic          cpu_cen,
  input  logic          cpu_bcystn,
  output logic [15:0]   cpu_do,
  output logic          cpu_readyn,
  output logic [AW-1:0] mem_a,
  output logic          mem_req,
  input  logic          mem_ack,
  input  logic [31:0]   mem_d,
  input  logic          flush,
  output logic [15:0]   hit_cnt,
  output logic [15:0]   miss_cnt
);

  localparam int unsigned IW = $clog2(LINES);
  localparam int unsigned TW = AW - IW - 2;

  typedef enum logic [1:0] {StIdle, StHit, StFill, StResp} state_e;

  state_e            state_q, state_d;
  logic [AW-1:1]     addr_q, addr_d;
  logic [31:0]       word_q, word_d;
  logic [15:0]       cpu_do_q, cpu_do_d;
  logic              mem_req_q, mem_req_d;
  logic [AW-1:0]     mem_a_q, mem_a_d;
  logic [15:0]       hit_cnt_q, hit_cnt_d;
  logic [15:0]       miss_cnt_q, miss_cnt_d;
  logic [LINES-1:0]  valid_q, valid_d;

  logic [31:0]       data_q [LINES];
  logic [TW-1:0]     tag_q  [LINES];

  logic [IW-1:0]     cpu_idx, fill_idx;
  logic [TW-1:0]     cpu_tag;
  logic              start, lookup_hit;
  logic              hit_inc, miss_inc, fill_we, respond;
  logic [15:0]       resp_half;

  // Byte lane bit is meaningless on a 16-bit port.
  logic              unused_a0;
  assign unused_a0 = cpu_a[0];

  assign cpu_idx    = cpu_a[IW+1:2];
  assign cpu_tag    = cpu_a[AW-1:IW+2];
  assign fill_idx   = addr_q[IW+1:2];
  assign start      = ce && !cpu_bcystn && !cpu_cen && (state_q == StIdle);
  assign lookup_hit = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
  assign resp_half  = addr_q[1] ? word_q[31:16] : word_q[15:0];

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    word_d    = word_q;
    mem_req_d = mem_req_q;
    mem_a_d   = mem_a_q;
    hit_inc   = 1'b0;
    miss_inc  = 1'b0;
    fill_we   = 1'b0;
    respond   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d = cpu_a[AW-1:1];
          if (lookup_hit) begin
            state_d = StHit;
            word_d  = data_q[cpu_idx];
            hit_inc = 1'b1;
          end else begin
            state_d   = StFill;
            mem_req_d = 1'b1;
            mem_a_d   = {cpu_a[AW-1:2], 2'b00};
            miss_inc  = 1'b1;
          end
        end
      end
      StHit: begin
        if (ce) begin
          respond = 1'b1;
          state_d = StIdle;
        end
      end
      StFill: begin
        // mem_ack is a single clk_cpu pulse and need not line up with ce.
        if (mem_ack) begin
          fill_we   = 1'b1;
          word_d    = mem_d;
          mem_req_d = 1'b0;
          state_d   = StResp;
        end
      end
      StResp: begin
        if (ce) begin
          respond = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    if (fill_we) begin
      valid_d[fill_idx] = 1'b1;
    end
    // A flush overrides a fill landing on the same cycle.
    if (flush) begin
      valid_d = '0;
    end
  end

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit_inc && (hit_cnt_q != 16'hFFFF)) begin
      hit_cnt_d = hit_cnt_q + 16'd1;
    end
    if (miss_inc && (miss_cnt_q != 16'hFFFF)) begin
      miss_cnt_d = miss_cnt_q + 16'd1;
    end
  end

  always_comb begin
    cpu_do_d   = cpu_do_q;
    cpu_readyn = 1'b1;
    if (respond) begin
      cpu_do_d   = resp_half;
      cpu_readyn = 1'b0;
    end
  end

  assign cpu_do   = cpu_do_d;
  assign mem_req  = mem_req_q;
  assign mem_a    = mem_a_q;
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      word_q     <= '0;
      cpu_do_q   <= '0;
      mem_req_q  <= 1'b0;
      mem_a_q    <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      cpu_do_q   <= cpu_do_d;
      mem_req_q  <= mem_req_d;
      mem_a_q    <= mem_a_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      valid_q    <= valid_d;
    end
  end

  // Storage needs no reset; the valid vector guards it.
  always_ff @(posedge clk_cpu) begin
    if (fill_we && !reset) begin
      data_q[fill_idx] <= mem_d;
      tag_q[fill_idx]  <= addr_q[AW-1:IW+2];
    end
  end

endmodule

// File: tb/tb_rom_line_buf.sv
// Directed bench for rom_line_buf: ce runs every other clock, fills are acked on non-ce cycles.
module tb_rom_line_buf;

  logic        clk_cpu = 1'b0;
  logic        reset, ce, cpu_cen, cpu_bcystn, mem_ack, flush;
  logic [19:0] cpu_a, mem_a;
  logic [15:0] cpu_do, hit_cnt, miss_cnt;
  logic        cpu_readyn, mem_req;
  logic [31:0] mem_d;

  int n_checks = 0;
  int n_fail   = 0;

  rom_line_buf dut (
    .clk_cpu    (clk_cpu),
    .reset      (reset),
    .ce         (ce),
    .cpu_a      (cpu_a),
    .cpu_cen    (cpu_cen),
    .cpu_bcystn (cpu_bcystn),
    .cpu_do     (cpu_do),
    .cpu_readyn (cpu_readyn),
    .mem_a      (mem_a),
    .mem_req    (mem_req),
    .mem_ack    (mem_ack),
    .mem_d      (mem_d),
    .flush      (flush),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
  );

  always #5 clk_cpu = ~clk_cpu;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout, required end of test");
    $fatal(1, "watchdog");
  end

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; ce alternates every clock and inputs settle before checks.
  task automatic next();
    @(posedge clk_cpu);
    #1;
    ce = ~ce;
    #1;
  endtask

  task automatic wait_ce();
    if (!ce) next();
  endtask

  task automatic access(input logic [19:0] a, input bit exp_hit, input logic [31:0] d,
                        input bit flush_on_ack, input logic [15:0] exp_do, input string tag);
    wait_ce();
    cpu_a      = a;
    cpu_cen    = 1'b0;
    cpu_bcystn = 1'b0;
    #1;
    next();
    cpu_bcystn = 1'b1;
    #1;
    if (exp_hit) begin
      chk({31'd0, mem_req}, 32'd0, {tag, "_noreq"});
      chk({31'd0, cpu_readyn}, 32'd1, {tag, "_rdy_early"});
      next();
    end else begin
      chk({31'd0, mem_req}, 32'd1, {tag, "_req"});
      chk({12'd0, mem_a}, {12'd0, a[19:2], 2'b00}, {tag, "_mem_a"});
      mem_ack = 1'b1;
      mem_d   = d;
      flush   = flush_on_ack;
      #1;
      next();
      mem_ack = 1'b0;
      flush   = 1'b0;
      #1;
      chk({31'd0, mem_req}, 32'd0, {tag, "_req_drop"});
    end
    chk({31'd0, cpu_readyn}, 32'd0, {tag, "_rdy"});
    chk({16'd0, cpu_do}, {16'd0, exp_do}, {tag, "_do"});
    next();
    cpu_cen = 1'b1;
    #1;
    chk({31'd0, cpu_readyn}, 32'd1, {tag, "_rdy_off"});
    chk({16'd0, cpu_do}, {16'd0, exp_do}, {tag, "_do_hold"});
  endtask

  initial begin
    reset = 1'b1; ce = 1'b0; cpu_cen = 1'b1; cpu_bcystn = 1'b1;
    mem_ack = 1'b0; flush = 1'b0; cpu_a = '0; mem_d = '0;
    repeat (3) next();
    chk({31'd0, cpu_readyn}, 32'd1, "rst_readyn");
    chk({16'd0, cpu_do}, 32'd0, "rst_do");
    chk({31'd0, mem_req}, 32'd0, "rst_req");
    chk({12'd0, mem_a}, 32'd0, "rst_mem_a");
    chk({16'd0, hit_cnt}, 32'd0, "rst_hit");
    chk({16'd0, miss_cnt}, 32'd0, "rst_miss");
    reset = 1'b0;

    access(20'h00010, 1'b0, 32'hDEADBEEF, 1'b0, 16'hBEEF, "miss10");
    chk({16'd0, miss_cnt}, 32'd1, "miss_cnt1");
    access(20'h00012, 1'b1, 32'h0, 1'b0, 16'hDEAD, "hit12");
    chk({16'd0, hit_cnt}, 32'd1, "hit_cnt1");
    access(20'h00410, 1'b0, 32'h11223344, 1'b0, 16'h3344, "miss410");
    chk({16'd0, miss_cnt}, 32'd2, "miss_cnt2");
    access(20'h00010, 1'b0, 32'hDEADBEEF, 1'b0, 16'hBEEF, "remiss10");
    chk({16'd0, miss_cnt}, 32'd3, "miss_cnt3");

    access(20'h00410, 1'b0, 32'h55667788, 1'b0, 16'h7788, "miss410b");
    access(20'h00412, 1'b1, 32'h0, 1'b0, 16'h5566, "hit412");
    flush = 1'b1;
    next();
    flush = 1'b0;
    access(20'h00410, 1'b0, 32'h99AABBCC, 1'b0, 16'hBBCC, "flush_miss410");
    chk({16'd0, hit_cnt}, 32'd2, "hit_cnt2");
    chk({16'd0, miss_cnt}, 32'd5, "miss_cnt5");

    access(20'h00020, 1'b0, 32'hCAFEF00D, 1'b1, 16'hF00D, "flush_ack20");
    access(20'h00022, 1'b0, 32'h12345678, 1'b0, 16'h1234, "after_flush22");
    // Stray ack while idle must not disturb the stored word.
    mem_ack = 1'b1;
    mem_d   = 32'h0BAD0BAD;
    next();
    mem_ack = 1'b0;
    access(20'h00020, 1'b1, 32'h0, 1'b0, 16'h5678, "hit20");
    chk({16'd0, hit_cnt}, 32'd3, "hit_cnt3");
    chk({16'd0, miss_cnt}, 32'd7, "miss_cnt7");

    wait_ce();
    cpu_a = 20'h00030; cpu_cen = 1'b0; cpu_bcystn = 1'b0;
    #1;
    next();
    cpu_bcystn = 1'b1;
    #1;
    chk({31'd0, mem_req}, 32'd1, "rstfill_req");
    reset = 1'b1;
    next();
    chk({31'd0, mem_req}, 32'd0, "rstfill_req_drop");
    reset   = 1'b0;
    cpu_cen = 1'b1;
    mem_ack = 1'b1;
    mem_d   = 32'hFFFF0000;
    next();
    mem_ack = 1'b0;
    #1;
    chk({16'd0, hit_cnt}, 32'd0, "rstfill_hit0");
    chk({16'd0, miss_cnt}, 32'd0, "rstfill_miss0");
    for (int i = 0; i < 3; i++) begin
      next();
      chk({31'd0, cpu_readyn}, 32'd1, "rstfill_no_rdy");
    end
    access(20'h00010, 1'b0, 32'hA5A55A5A, 1'b0, 16'h5A5A, "post_rst_miss");
    chk({16'd0, miss_cnt}, 32'd1, "post_rst_miss1");

    for (int i = 0; i < 3; i++) begin
      access(20'h00012, 1'b1, 32'h0, 1'b0, 16'hA5A5, "sat_hit");
    end
    chk({16'd0, hit_cnt}, 32'd3, "sat_hit3");
    // Jump near the top instead of spending ~65k real accesses.
    force dut.hit_cnt_q = 16'hFFFD;
    #1;
    release dut.hit_cnt_q;
    access(20'h00012, 1'b1, 32'h0, 1'b0, 16'hA5A5, "sat_a");
    chk({16'd0, hit_cnt}, 32'h0000FFFE, "sat_fffe");
    access(20'h00012, 1'b1, 32'h0, 1'b0, 16'hA5A5, "sat_b");
    chk({16'd0, hit_cnt}, 32'h0000FFFF, "sat_ffff");
    access(20'h00010, 1'b1, 32'h0, 1'b0, 16'h5A5A, "sat_c");
    chk({16'd0, hit_cnt}, 32'h0000FFFF, "sat_hold1");
    access(20'h00012, 1'b1, 32'h0, 1'b0, 16'hA5A5, "sat_d");
    chk({16'd0, hit_cnt}, 32'h0000FFFF, "sat_hold2");
    chk({16'd0, miss_cnt}, 32'd1, "sat_miss1");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_line_buf.md
Name: rom_line_buf

Overview:
- Direct-mapped read buffer between the machine's 16-bit ROM port and the SDRAM memory interface. Lives entirely in the CPU clock domain.
- Serves repeated BIOS fetches from local storage with fixed hit latency. Misses become 32-bit word reads on the downstream request/acknowledge port.
- Exposes hit/miss counters for bring-up.

Parameters:
- LINES, 16: number of buffer entries; power of two, 2..64.
- AW, 20: ROM byte-address width.

Ports:
- clk_cpu  in  1  CPU clock.
- reset  in  1  synchronous, active-high.
- ce  in  1  CPU clock enable; CPU-side sampling and responses occur only on ce cycles.
- cpu_a  in  AW  ROM byte address; bit 0 ignored.
- cpu_cen  in  1  ROM chip enable, active-low.
- cpu_bcystn  in  1  bus-cycle start strobe, active-low.
- cpu_do  out  16  read data.
- cpu_readyn  out  1  ready, active-low.
- mem_a  out  AW  word-aligned fetch address, bits [1:0] = 0.
- mem_req  out  1  fetch request level.
- mem_ack  in  1  one-clk_cpu pulse; mem_d valid on that cycle.
- mem_d  in  32  fetched word; byte 0 at bits [7:0].
- flush  in  1  invalidate all entries.
- hit_cnt  out  16  saturating hit count.
- miss_cnt  out  16  saturating miss count.

Behaviour:
- Geometry:
  - Index = cpu_a[IW+1:2], where IW = log2(LINES).
  - Tag = cpu_a[AW-1:IW+2].
  - Per entry: 32-bit data, tag, and one bit of a LINES-bit valid register vector.
  - Halfword select = cpu_a[1]: 0 returns data[15:0], 1 returns data[31:16].
- Reset values: all valid bits 0; cpu_readyn=1; cpu_do=0; mem_req=0; mem_a=0; hit_cnt=0; miss_cnt=0; state IDLE.
- States: IDLE, HIT, FILL, RESP.
- Access start: a ce cycle with cpu_bcystn=0 and cpu_cen=0 while in IDLE. On that cycle, latch the address and look up the entry.
  - Hit (valid and tag match) -> HIT.
  - Miss -> FILL; assert mem_req with mem_a = {addr[AW-1:2],2'b00}.
- HIT: on the next ce cycle, drive cpu_do and set cpu_readyn=0 for exactly that one ce cycle, then return to IDLE. Hit latency is 1 ce period after the start cycle.
- FILL:
  - mem_req stays high until the clk_cpu cycle on which mem_ack=1. That cycle writes data and tag, sets valid, deasserts mem_req, and goes to RESP.
  - mem_ack may arrive on a non-ce cycle.
- RESP: on the first ce cycle after entering RESP, drive cpu_do from the filled word, set cpu_readyn=0 for that ce cycle, then return to IDLE.
- cpu_readyn is high on every ce cycle other than those stated above. cpu_do holds its last value between accesses.
- A start strobe while not in IDLE is ignored. The CPU must wait for ready.
- mem_ack while not in FILL is ignored; no state or data change.
- flush:
  - Clears every valid bit on the clk_cpu cycle it is high.
  - During FILL, the in-flight fill still completes and answers the CPU, but does not set valid.
  - flush coincident with the mem_ack cycle: flush wins; the entry stays invalid.
- Counters:
  - hit_cnt increments on each IDLE->HIT transition; miss_cnt increments on each IDLE->FILL transition.
  - Both saturate at 16'hFFFF.
  - Both are cleared only by reset, not by flush.
- reset mid-FILL: mem_req drops on the next cycle, state returns to IDLE, and a late mem_ack is ignored.
- An access whose cpu_cen rises before ready still completes its fill. The ready pulse is still generated; the CPU ignores it.

Test Plan:
- After reset, start read at 0x00010 (ce every other clock) -> mem_req=1, mem_a=0x00010. mem_ack with mem_d=0xDEADBEEF on a non-ce cycle -> next ce: cpu_readyn=0, cpu_do=0xBEEF. miss_cnt=1.
- Repeat the read at 0x00012 -> no mem_req; one ce period later cpu_readyn=0, cpu_do=0xDEAD. hit_cnt=1.
- Read 0x00410 (same index 4, different tag) -> miss and refill. A following read of 0x00010 misses again (miss_cnt=3).
- Pulse flush, then read 0x00410 -> miss. Separately, assert flush on the mem_ack cycle of a fill -> CPU receives the data, and a re-read of the same address misses.
- Assert reset while in FILL with mem_req=1 -> mem_req=0 next cycle, then inject mem_ack -> no cpu_readyn pulse, counters 0, subsequent read misses.
- Issue 65540 reads of one address -> hit_cnt saturates at 0xFFFF, miss_cnt=1.
